// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// and the size-to-byte-mask mapping.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC_LO,
        ST_ACC_HI,
        ST_RESP
    } state_e;

    // Encoding 2'b11 falls into the word case.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 4'b0001;
            SIZE_H:  return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte-enable mask and store data spread across
// two words, plus extraction and extension of load data from the two words.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic [7:0]  mask8_o,
    output logic [63:0] wdata64_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  sh;
    logic [31:0] ld32;

    assign sh        = {off_i, 3'b000};
    assign mask8_o   = {4'b0000, size_mask(size_i)} << off_i;
    assign wdata64_o = {32'h0, wdata_i} << sh;
    // Only the low word of the shifted pair can hold requested bytes.
    assign ld32      = 32'({hi_i, lo_i} >> sh);

    always_comb begin
        rdata_o = ld32;
        case (size_i)
            SIZE_B:  rdata_o = uns_i ? {24'h0, ld32[7:0]}  : {{24{ld32[7]}}, ld32[7:0]};
            SIZE_H:  rdata_o = uns_i ? {16'h0, ld32[15:0]} : {{16{ld32[15]}}, ld32[15:0]};
            default: rdata_o = ld32;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns byte/half/word requests at any byte address into
// one or two word-aligned accesses and returns extended load data.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_split,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    state_e      state_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;

    logic [7:0]  mask8;
    logic [63:0] wdata64;
    logic [31:0] ld_data;
    logic        split;
    logic [31:0] word_addr;

    lsu_align u_align (
        .size_i    (size_q),
        .off_i     (addr_q[1:0]),
        .uns_i     (uns_q),
        .wdata_i   (wdata_q),
        .lo_i      (lo_q),
        .hi_i      (hi_q),
        .mask8_o   (mask8),
        .wdata64_o (wdata64),
        .rdata_o   (ld_data)
    );

    assign split     = |mask8[7:4];
    assign word_addr = {addr_q[31:2], 2'b00};
    assign req_ready = rst_n && (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        // hi_q must read as zero for a non-split load.
                        lo_q    <= '0;
                        hi_q    <= '0;
                        state_q <= ST_ACC_LO;
                    end
                end
                ST_ACC_LO: begin
                    if (!write_q) lo_q <= mem_read_data;
                    state_q <= split ? ST_ACC_HI : ST_RESP;
                end
                ST_ACC_HI: begin
                    if (!write_q) hi_q <= mem_read_data;
                    state_q <= ST_RESP;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_byte_enable  = '0;
        mem_write_enable = 1'b0;
        resp_valid       = 1'b0;
        resp_rdata       = '0;
        resp_split       = 1'b0;
        case (state_q)
            ST_ACC_LO: begin
                mem_address      = word_addr;
                mem_byte_enable  = mask8[3:0];
                mem_write_data   = wdata64[31:0];
                mem_write_enable = write_q && (|mask8[3:0]);
            end
            ST_ACC_HI: begin
                // Wraps naturally from 0xFFFFFFFC to 0x00000000.
                mem_address      = word_addr + 32'd4;
                mem_byte_enable  = mask8[7:4];
                mem_write_data   = wdata64[63:32];
                mem_write_enable = write_q && (|mask8[7:4]);
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = write_q ? 32'h0 : ld_data;
                resp_split = split;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort and back-to-back
// sequences, and random traffic checked against a byte-level memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_split;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    load_store_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_split       (resp_split),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_byte_enable  (mem_byte_enable),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural word memory: 16 words selected by address bits [5:2].
    logic [31:0] mem [16];
    logic        mem_clr;
    logic        pre_en;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;
    wr_t wr_q[$];
    int  misalign;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_write_enable) begin
            for (int i = 0; i < 4; i++)
                if (mem_byte_enable[i]) mem[mem_address[5:2]][8*i +: 8] <= mem_write_data[8*i +: 8];
        end
        if (mem_write_enable) wr_q.push_back('{mem_address, mem_byte_enable, mem_write_data});
        if (mem_address[1:0] != 2'b00) misalign <= misalign + 1;
    end

    always_comb mem_read_data = mem[mem_address[5:2]];

    // Reference model: byte-addressed memory, 64 bytes, wraps like the bench memory.
    logic [7:0] ref_b [64];
    int total;
    int bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model(input logic w, input logic [31:0] a, input logic [1:0] s, input logic u,
                         input logic [31:0] wd, output logic [31:0] rd, output logic sp);
        int          n;
        logic [31:0] v;
        logic [31:0] ba;
        n  = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        sp = (int'(a[1:0]) + n) > 4;
        v  = '0;
        for (int k = 0; k < n; k++) begin
            ba = a + 32'(k);
            if (w) ref_b[int'(ba[5:0])] = wd[8*k +: 8];
            else   v[8*k +: 8] = ref_b[int'(ba[5:0])];
        end
        if (!w && !u && v[8*n-1])
            for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
        rd = w ? 32'h0 : v;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = 4'(idx);
        pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
        for (int k = 0; k < 4; k++) ref_b[idx*4 + k] = val[8*k +: 8];
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] s, input logic u,
                          input logic [31:0] wd, output logic [31:0] rd, output logic sp, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = s;
        req_unsigned = u; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready timeout", {31'h0, req_ready}, 32'h1);
        lat = 0; rd = '0; sp = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; sp = resp_split;
                break;
            end
        end
    endtask

    typedef struct {
        logic        pre;
        logic [3:0]  pi0;
        logic [31:0] pv0;
        logic [3:0]  pi1;
        logic [31:0] pv1;
        logic        w;
        logic [31:0] a;
        logic [1:0]  s;
        logic        u;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        esp;
        int          elat;
        int          nwr;
        logic [31:0] wa0;
        logic [3:0]  wb0;
        logic [31:0] wv0;
        logic [31:0] wa1;
        logic [3:0]  wb1;
        logic [31:0] wv1;
    } vec_t;

    localparam int NV = 13;
    localparam int NB = 6;
    vec_t vec [NV];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, erd;
        logic        sp, esp;
        int          lat, wb, rv;
        logic        bw [NB];
        logic [31:0] ba [NB];
        logic [1:0]  bs [NB];
        logic        bu [NB];
        logic [31:0] bwd [NB];
        logic [31:0] brd [NB];
        logic        bsp [NB];
        int          acc, rsp, last_c;
        logic        rdy_prev;

        total = 0; bad = 0; misalign = 0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        for (int i = 0; i < 64; i++) ref_b[i] = 8'h0;

        vec[0]  = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b1,32'h10,2'd2,1'b0,32'hDEADBEEF, 32'h0,1'b0,2, 1, 32'h10,4'hF,32'hDEADBEEF, 32'h0,4'h0,32'h0};
        vec[1]  = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b0,32'h10,2'd2,1'b0,32'h0, 32'hDEADBEEF,1'b0,2, 0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
        vec[2]  = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b1,32'h13,2'd0,1'b0,32'hFFFFFFAB, 32'h0,1'b0,2, 1, 32'h10,4'h8,32'hAB000000, 32'h0,4'h0,32'h0};
        vec[3]  = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b0,32'h13,2'd0,1'b0,32'h0, 32'hFFFFFFAB,1'b0,2, 0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
        vec[4]  = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b0,32'h13,2'd0,1'b1,32'h0, 32'h000000AB,1'b0,2, 0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
        vec[5]  = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b0,32'h10,2'd3,1'b0,32'h0, 32'hABADBEEF,1'b0,2, 0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
        vec[6]  = '{1'b1,4'h3,32'hAABBCCDD,4'h4,32'h11223344, 1'b0,32'h0E,2'd2,1'b0,32'h0, 32'h3344AABB,1'b1,3, 0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
        vec[7]  = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b1,32'hFFFFFFFE,2'd2,1'b0,32'h12345678, 32'h0,1'b1,3, 2, 32'hFFFFFFFC,4'hC,32'h56780000, 32'h0,4'h3,32'h00001234};
        vec[8]  = '{1'b1,4'h3,32'h11223344,4'h4,32'h55667788, 1'b1,32'h0F,2'd1,1'b0,32'h0000BEEF, 32'h0,1'b1,3, 2, 32'h0C,4'h8,32'hEF000000, 32'h10,4'h1,32'h000000BE};
        vec[9]  = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b0,32'h0F,2'd1,1'b0,32'h0, 32'hFFFFBEEF,1'b1,3, 0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
        vec[10] = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b0,32'h0F,2'd1,1'b1,32'h0, 32'h0000BEEF,1'b1,3, 0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
        vec[11] = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b0,32'h0E,2'd1,1'b0,32'h0, 32'hFFFFEF22,1'b0,2, 0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
        vec[12] = '{1'b0,4'h0,32'h0,4'h0,32'h0, 1'b1,32'h11,2'd1,1'b0,32'h1234A5A5, 32'h0,1'b0,2, 1, 32'h10,4'h6,32'h34A5A500, 32'h0,4'h0,32'h0};

        // Reset, memory cleared, all outputs quiet.
        rst_n = 1'b0; mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset req_ready", {31'h0, req_ready}, 32'h0);
        chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset mem_we", {31'h0, mem_write_enable}, 32'h0);
        chk("reset mem_be", {28'h0, mem_byte_enable}, 32'h0);
        chk("reset mem_addr", mem_address, 32'h0);
        chk("reset mem_wdata", mem_write_data, 32'h0);
        rst_n = 1'b1; mem_clr = 1'b0;
        #1;
        chk("ready after reset", {31'h0, req_ready}, 32'h1);

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            if (vec[i].pre) begin
                preload(int'(vec[i].pi0), vec[i].pv0);
                preload(int'(vec[i].pi1), vec[i].pv1);
            end
            wb = wr_q.size();
            do_req(vec[i].w, vec[i].a, vec[i].s, vec[i].u, vec[i].wd, rd, sp, lat);
            model(vec[i].w, vec[i].a, vec[i].s, vec[i].u, vec[i].wd, erd, esp);
            chk($sformatf("vec%0d rdata", i), rd, vec[i].erd);
            chk($sformatf("vec%0d split", i), {31'h0, sp}, {31'h0, vec[i].esp});
            chk($sformatf("vec%0d latency", i), lat, vec[i].elat);
            chk($sformatf("vec%0d nwrites", i), wr_q.size() - wb, vec[i].nwr);
            if (wr_q.size() - wb >= 1 && vec[i].nwr >= 1) begin
                chk($sformatf("vec%0d w0 addr", i), wr_q[wb].addr, vec[i].wa0);
                chk($sformatf("vec%0d w0 be", i), {28'h0, wr_q[wb].be}, {28'h0, vec[i].wb0});
                chk($sformatf("vec%0d w0 data", i), wr_q[wb].data, vec[i].wv0);
            end
            if (wr_q.size() - wb >= 2 && vec[i].nwr >= 2) begin
                chk($sformatf("vec%0d w1 addr", i), wr_q[wb+1].addr, vec[i].wa1);
                chk($sformatf("vec%0d w1 be", i), {28'h0, wr_q[wb+1].be}, {28'h0, vec[i].wb1});
                chk($sformatf("vec%0d w1 data", i), wr_q[wb+1].data, vec[i].wv1);
            end
        end
        chk("mem 0x0C", mem[3], 32'hEF223344);
        chk("mem 0x10", mem[4], 32'h55A5A5BE);
        chk("mem 0xFFFFFFFC", mem[15], 32'h56780000);
        chk("mem 0x00", mem[0], 32'h00001234);

        // Reset during the first access of a split store aborts the request.
        wb = wr_q.size();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h22; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort acc_lo we", {31'h0, mem_write_enable}, 32'h1);
        chk("abort acc_lo be", {28'h0, mem_byte_enable}, 32'hC);
        chk("abort acc_lo addr", mem_address, 32'h20);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort ready in reset", {31'h0, req_ready}, 32'h0);
        chk("abort we in reset", {31'h0, mem_write_enable}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("abort ready after release", {31'h0, req_ready}, 32'h1);
        rv = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        chk("abort resp count", rv, 0);
        chk("abort write count", wr_q.size() - wb, 1);
        ref_b[8'h22] = 8'h0D;
        ref_b[8'h23] = 8'hF0;

        // Back-to-back traffic with req_valid held high.
        for (int i = 0; i < NB; i++) begin
            bw[i]  = (i % 3 == 1);
            ba[i]  = $urandom;
            bs[i]  = 2'($urandom_range(0, 3));
            bu[i]  = 1'($urandom_range(0, 1));
            bwd[i] = $urandom;
        end
        ba[0] = 32'h0000001E; bs[0] = 2'd2; bw[0] = 1'b0;
        for (int i = 0; i < NB; i++) model(bw[i], ba[i], bs[i], bu[i], bwd[i], brd[i], bsp[i]);
        @(negedge clk);
        req_valid = 1'b1; req_write = bw[0]; req_addr = ba[0]; req_size = bs[0];
        req_unsigned = bu[0]; req_wdata = bwd[0];
        rdy_prev = req_ready;
        acc = 0; rsp = 0; last_c = 0;
        for (int c = 0; c < 200 && rsp < NB; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                chk("b2b order", {31'h0, rsp < acc}, 32'h1);
                if (rsp < NB) begin
                    chk($sformatf("b2b%0d rdata", rsp), resp_rdata, brd[rsp]);
                    chk($sformatf("b2b%0d split", rsp), {31'h0, resp_split}, {31'h0, bsp[rsp]});
                end
                rsp++;
            end
            if (rdy_prev) begin
                if (acc > 0) chk($sformatf("b2b%0d gap", acc), c - last_c, bsp[acc-1] ? 4 : 3);
                last_c = c;
                acc++;
                if (acc < NB) begin
                    req_write = bw[acc]; req_addr = ba[acc]; req_size = bs[acc];
                    req_unsigned = bu[acc]; req_wdata = bwd[acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
            rdy_prev = req_ready && req_valid;
        end
        req_valid = 1'b0;
        chk("b2b accepted", acc, NB);
        chk("b2b responses", rsp, NB);

        // Random traffic against the byte-level model.
        for (int i = 0; i < 40; i++) begin
            logic        w, u;
            logic [31:0] a, wd;
            logic [1:0]  s;
            w  = 1'($urandom_range(0, 1));
            a  = $urandom;
            s  = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            wd = $urandom;
            do_req(w, a, s, u, wd, rd, sp, lat);
            model(w, a, s, u, wd, erd, esp);
            chk($sformatf("rnd%0d rdata", i), rd, erd);
            chk($sformatf("rnd%0d split", i), {31'h0, sp}, {31'h0, esp});
            chk($sformatf("rnd%0d latency", i), lat, esp ? 3 : 2);
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            chk($sformatf("final mem%0d", i), mem[i],
                {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});
        chk("aligned address", misalign, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's word-addressed data-memory request interface. It accepts byte, half and word load/store requests at any byte address from the execute stage. It converts each request into one or two word-aligned memory accesses with byte enables, and returns the aligned, sign- or zero-extended load data. It sits between the core datapath and the data memory, and it is the only block that drives the memory's address, write-data, byte-enable and write-enable inputs.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address, any alignment
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores
- resp_split  out  1  with resp_valid: request needed two accesses
- mem_address  out  32  word-aligned address, bits [1:0] always 00
- mem_write_data  out  32  byte-lane-positioned store data
- mem_byte_enable  out  4  lane mask
- mem_write_enable  out  1  write strobe
- mem_read_data  in  32  combinational read of mem_address, same cycle

## Operation
- FSM states: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE: req_ready = 1. On handshake, latch write, addr, size, unsigned and wdata, then go to ACC_LO.
- ACC_LO:
  - mem_address = {addr[31:2], 2'b00}
  - mem_byte_enable = mask8[3:0]
  - mem_write_data = wdata64[31:0]
  - mem_write_enable = write & (mask8[3:0] != 0)
  - Loads: capture mem_read_data into lo_q at the clock edge.
  - If mask8[7:4] != 0, go to ACC_HI; otherwise go to RESP.
- ACC_HI:
  - mem_address = {addr[31:2], 2'b00} + 4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000)
  - mem_byte_enable = mask8[7:4]
  - mem_write_data = wdata64[63:32]
  - Loads: capture mem_read_data into hi_q at the clock edge, then go to RESP.
- RESP: resp_valid = 1 and resp_rdata is driven. Go to IDLE. There is no backpressure on the response.
- Width rules, with off = addr[1:0]:
  - smask = 0001 / 0011 / 1111 for byte / half / word
  - mask8 = {4'b0, smask} << off
  - wdata64 = {32'b0, wdata} << (8*off)
  - Load: ld64 = {hi_q, lo_q} >> (8*off); take ld64[7:0], [15:0] or [31:0] and extend per unsigned. hi_q is 0 when the access is not split.
- Outside ACC_LO/ACC_HI: mem_write_enable = 0, mem_byte_enable = 0, mem_address = 0, mem_write_data = 0.
- Reset: state goes to IDLE and lo_q, hi_q and all latched fields clear. req_ready = 0 while rst_n = 0. Reset in any state aborts the request: no further memory write, no resp_valid.
- Inputs are ignored outside IDLE. A held req_valid is accepted on the first IDLE cycle.

## Timing
- Accept edge = T. Non-split request: ACC_LO in cycle T+1, resp_valid in cycle T+2. Split request: ACC_LO in T+1, ACC_HI in T+2, resp_valid in T+3.
- Throughput: one request per 3 cycles non-split, one per 4 cycles split. req_ready is low from T+1 until RESP completes.
- All outputs are combinational from state and latched registers only; there is no path from req_* to mem_*.

## Structure
- lsu_pkg holds:
  - the size enum (SIZE_B, SIZE_H, SIZE_W)
  - the FSM state enum
  - a size-to-mask function
- One sub-module, lsu_align, is combinational and computes mask8, wdata64 and load extraction/extension. The FSM and registers live in load_store_unit.

## Test plan
The bench uses a behavioural word memory that writes only enabled lanes and returns a combinational read.
- Word store 0xDEADBEEF @0x10, then load word @0x10 -> one write at addr 0x10 with be 1111; resp_rdata = 0xDEADBEEF at T+2; resp_split = 0.
- Byte store 0xAB @0x13 -> be 1000, mem_write_data 0xAB000000. Signed byte load @0x13 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half store 0xBEEF @0x0F, with mem[0x0C] = 0x11223344 and mem[0x10] = 0x55667788 -> write 0x0C be 1000 data 0xEF000000, then write 0x10 be 0001 data 0x000000BE. Memory ends 0xEF223344 / 0x556677BE. Signed half load @0x0F -> 0xFFFFBEEF at T+3, resp_split = 1.
- Word load @0x0E, with mem[0x0C] = 0xAABBCCDD and mem[0x10] = 0x11223344 -> resp_rdata 0x3344AABB. Word store @0xFFFFFFFE -> second access at mem_address 0x00000000 with be 0011.
- rst_n low during ACC_LO of a split store -> no ACC_HI write, no resp_valid; req_ready = 1 on the first cycle after release.
- req_valid held high with back-to-back requests -> each accepted only in IDLE; exactly one resp_valid per accepted request, in order.
